// File: rtl/fifo_rd_stream_adapter.sv
// Drains a synchronous FIFO into a valid/ready stream through a 3-entry buffer; fifo_rd_en -> m_valid is 2 cycles.
// m_ready low fills the buffer and then stops reads; STREAM_STATS_EN adds word_count and a sticky err_underflow.
module fifo_rd_stream_adapter #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 8
`ifdef STREAM_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  err_underflow
`endif
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);

  logic [FIFO_WIDTH-1:0] mem_q [3];
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [BW-1:0]         beat_q, beat_d;
  logic [2:0]            occ_sum;
  logic                  capture;
  logic                  xfer;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Space is judged on occupancy plus the read already in flight, so the
  // buffer never overflows and m_ready has no path to fifo_rd_en.
  always_comb begin
    occ_sum    = {1'b0, occ_q} + {2'b00, inflight_q};
    fifo_rd_en = !rst && en && !fifo_empty && (occ_sum < 3'd3);
    capture    = inflight_q && !fifo_underflow;
    m_valid    = (occ_q != 2'd0);
    xfer       = m_valid && m_ready;
    m_data     = mem_q[head_q];
    m_last     = m_valid && (beat_q == BEAT_LAST);

    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    if (capture && !xfer) begin
      occ_d = occ_q + 2'd1;
    end else if (!capture && xfer) begin
      occ_d = occ_q - 2'd1;
    end
    if (capture) begin
      tail_d = ptr_inc(tail_q);
    end
    if (xfer) begin
      head_d = ptr_inc(head_q);
      beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      mem_q[2]   <= '0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      if (capture) begin
        mem_q[tail_q] <= fifo_data_out;
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
    end
  end

`ifdef STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] word_count_q;
  logic                 err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (xfer) begin
        word_count_q <= word_count_q + CNT_WIDTH'(1);
      end
      if (inflight_q && fifo_underflow) begin
        err_q <= 1'b1;
      end
    end
  end

  assign word_count    = word_count_q;
  assign err_underflow = err_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: FIFO model, queue scoreboard, scenario table, corner sequences, random traffic.
module tb_fifo_rd_stream_adapter;

  localparam int W  = 16;
  localparam int PL = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         m_ready = 1'b0;
  logic         force_empty = 1'b0;
  logic         fifo_empty;
  logic         fifo_underflow;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_last;
  logic [W-1:0] fifo_data_out;
  logic [W-1:0] m_data;
`ifdef STREAM_STATS_EN
  logic [15:0]  word_count;
  logic         err_underflow;
`endif

  logic [W-1:0] mem [256];
  logic [7:0]   rdp;
  logic [7:0]   wrp = 8'd0;
  logic [8:0]   uf_pick = 9'h1FF;

  fifo_rd_stream_adapter #(.FIFO_WIDTH(W), .PKT_LEN(PL)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_data_out(fifo_data_out),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
`ifdef STREAM_STATS_EN
    , .word_count(word_count), .err_underflow(err_underflow)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: one-cycle read latency; the read numbered uf_pick is flagged as underflow.
  assign fifo_empty = force_empty || (rdp == wrp);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdp            <= 8'd0;
      fifo_data_out  <= '0;
      fifo_underflow <= 1'b0;
    end else begin
      fifo_underflow <= 1'b0;
      if (fifo_rd_en) begin
        fifo_data_out  <= mem[rdp];
        rdp            <= rdp + 8'd1;
        fifo_underflow <= ({1'b0, rdp} == uf_pick);
      end
    end
  end

  int           n_cmp = 0;
  int           n_err = 0;
  int           n_reads, n_drops, beats, tot;
  logic         inflight_m, prev_stall, prev_last, err_m;
  logic [W-1:0] prev_data;
  logic [W-1:0] exp_q [$];

  typedef struct {
    int   nwords;
    logic en;
    logic rdy;
    int   cycles;
    int   exp_reads;
    int   exp_beats;
    logic exp_valid;
  } row_t;
  row_t rows [5];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model at negedge: items read but not yet captured/dropped/sent bound
  // issue; captured words are queued and must leave in order with m_last every PL beats.
  task automatic mon();
    int outstanding;
    if (rst) begin
      exp_q.delete();
      n_reads = 0; n_drops = 0; beats = 0;
      inflight_m = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; err_m = 1'b0;
      prev_data = '0;
      return;
    end
    outstanding = n_reads - n_drops - beats;
    chk1("rd_en rule", fifo_rd_en, en && !fifo_empty && (outstanding < 3));
    chk1("m_valid vs occupancy", m_valid, exp_q.size() != 0);
    if (m_valid && exp_q.size() != 0) begin
      chkd("m_data order", int'(m_data), int'(exp_q[0]));
      chk1("m_last framing", m_last, (beats % PL) == PL - 1);
    end else begin
      chk1("m_last idle", m_last, 1'b0);
    end
    if (prev_stall) begin
      chk1("stall valid held", m_valid, 1'b1);
      chkd("stall data held", int'(m_data), int'(prev_data));
      chk1("stall last held", m_last, prev_last);
    end
`ifdef STREAM_STATS_EN
    chkd("word_count", int'(word_count), beats % 65536);
    chk1("err_underflow", err_underflow, err_m);
`endif
    if (m_valid && m_ready && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      beats++;
    end
    if (inflight_m) begin
      if (fifo_underflow) begin
        n_drops++;
        err_m = 1'b1;
      end else begin
        exp_q.push_back(fifo_data_out);
      end
    end
    if (fifo_rd_en) n_reads++;
    inflight_m = fifo_rd_en;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_reset();
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
    uf_pick = 9'h1FF; wrp = 8'd0; tot = 0;
    cyc();
    cyc();
  endtask

  task automatic push(input logic [W-1:0] v);
    mem[wrp] = v;
    wrp = wrp + 8'd1;
    tot++;
  endtask

  initial begin
    rows[0] = '{6, 1'b1, 1'b0, 10, 3, 0, 1'b1};
    rows[1] = '{2, 1'b1, 1'b0, 10, 2, 0, 1'b1};
    rows[2] = '{0, 1'b1, 1'b1, 10, 0, 0, 1'b0};
    rows[3] = '{5, 1'b1, 1'b1, 12, 5, 5, 1'b0};
    rows[4] = '{8, 1'b0, 1'b1, 10, 0, 0, 1'b0};

    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none

    begin_reset();
    chk1("reset rd_en", fifo_rd_en, 1'b0);
    chk1("reset m_valid", m_valid, 1'b0);
    chk1("reset m_last", m_last, 1'b0);
    chkd("reset m_data", int'(m_data), 0);

    for (int i = 0; i < 5; i++) begin
      begin_reset();
      for (int k = 1; k <= rows[i].nwords; k++) push(16'(k));
      en = rows[i].en;
      m_ready = rows[i].rdy;
      rst = 1'b0;
      repeat (rows[i].cycles) cyc();
      chkd("row reads", n_reads, rows[i].exp_reads);
      chkd("row beats", beats, rows[i].exp_beats);
      chk1("row m_valid", m_valid, rows[i].exp_valid);
    end

    // Async reset with occ=2 and a read about to issue.
    begin_reset();
    push(16'h00A1); push(16'h00A2);
    en = 1'b1; m_ready = 1'b0; rst = 1'b0;
    repeat (6) cyc();
    chk1("t1 valid before rst", m_valid, 1'b1);
    push(16'h00A3);
    #1;
    chk1("t1 rd_en before rst", fifo_rd_en, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("t1 async rd_en", fifo_rd_en, 1'b0);
    chk1("t1 async m_valid", m_valid, 1'b0);
    chk1("t1 async m_last", m_last, 1'b0);
    begin_reset();
    en = 1'b1; m_ready = 1'b1; rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk1("t1 no stale beat", m_valid, 1'b0);
    end

    // Latency and one packet of 8.
    begin_reset();
    for (int k = 1; k <= 8; k++) push(16'(k));
    en = 1'b1; m_ready = 1'b1; rst = 1'b0;
    smp();
    chk1("t2 rd_en first cycle", fifo_rd_en, 1'b1);
    chk1("t2 valid c0", m_valid, 1'b0);
    smp();
    chk1("t2 valid c1", m_valid, 1'b0);
    smp();
    chk1("t2 valid c2", m_valid, 1'b1);
    chkd("t2 data c2", int'(m_data), 1);
    chk1("t2 last c2", m_last, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      smp();
      chk1("t2 valid stream", m_valid, 1'b1);
      chkd("t2 data stream", int'(m_data), k);
      chk1("t2 last stream", m_last, k == 8);
    end
    smp();
    chk1("t2 valid after", m_valid, 1'b0);

    // Backpressure then release with no gaps.
    begin_reset();
    for (int k = 1; k <= 6; k++) push(16'(k));
    en = 1'b1; m_ready = 1'b0; rst = 1'b0;
    repeat (10) cyc();
    chkd("t3 reads stalled", n_reads, 3);
    chk1("t3 valid stalled", m_valid, 1'b1);
    chkd("t3 data stalled", int'(m_data), 1);
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk1("t3 no gap", m_valid, 1'b1);
    end
    smp();
    chk1("t3 drained", m_valid, 1'b0);
    chkd("t3 beats", beats, 6);

    // en pause after the third read.
    begin_reset();
    for (int k = 1; k <= 16; k++) push(16'(k));
    en = 1'b1; m_ready = 1'b1; rst = 1'b0;
    for (int g = 0; g < 20 && n_reads < 3; g++) cyc();
    chkd("t4 reads before pause", n_reads, 3);
    en = 1'b0;
    repeat (10) cyc();
    chkd("t4 reads paused", n_reads, 3);
    chkd("t4 beats paused", beats, 3);
    chk1("t4 valid paused", m_valid, 1'b0);
    en = 1'b1;
    smp();
    smp();
    smp();
    chkd("t4 resume data", int'(m_data), 4);
    repeat (20) cyc();
    chkd("t4 beats total", beats, 16);

    // Empty flag blocks reads regardless of space.
    begin_reset();
    for (int k = 1; k <= 4; k++) push(16'(k));
    force_empty = 1'b1; en = 1'b1; m_ready = 1'b1; rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk1("t5 rd_en empty", fifo_rd_en, 1'b0);
      chk1("t5 valid empty", m_valid, 1'b0);
    end
    cyc();
    force_empty = 1'b0;
    repeat (15) cyc();
    chkd("t5 beats after", beats, 4);

    // Underflow on the third of four reads.
    begin_reset();
    for (int k = 1; k <= 4; k++) push(16'(k));
    uf_pick = 9'd2;
    en = 1'b1; m_ready = 1'b1; rst = 1'b0;
    repeat (15) cyc();
    chkd("t6 beats", beats, 3);
    chkd("t6 drops", n_drops, 1);
`ifdef STREAM_STATS_EN
    chk1("t6 err set", err_underflow, 1'b1);
    chkd("t6 word_count", int'(word_count), 3);
    repeat (5) cyc();
    chk1("t6 err sticky", err_underflow, 1'b1);
`endif

    // Random traffic against the scoreboard.
    for (int r = 0; r < 6; r++) begin
      int n;
      begin_reset();
      n = $urandom_range(0, 20);
      for (int k = 0; k < n; k++) push(16'($urandom));
      uf_pick = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 60)) : 9'h1FF;
      en = 1'b1; rst = 1'b0;
      for (int c = 0; c < 300; c++) begin
        cyc();
        en = ($urandom_range(0, 3) != 0);
        m_ready = ($urandom_range(0, 2) != 0);
        force_empty = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 2) == 0 && tot < 200) push(16'($urandom));
      end
      en = 1'b1; m_ready = 1'b1; force_empty = 1'b0;
      for (int g = 0; g < 600 && (beats + n_drops) < tot; g++) cyc();
      repeat (4) cyc();
      chkd("rand all words accounted", beats + n_drops, tot);
      chkd("rand scoreboard empty", exp_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
